// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants and helpers for the N-to-1 stream mux
package stream_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Index width that never collapses to zero bits, so N=2 still gets a 1-bit select.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_vld,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [N-1:0]   rot;
  logic [SEL_W:0] rot_sum;
  logic [SEL_W:0] off;
  logic [SEL_W:0] idx_sum;

  // rot[k] is the request k positions after ptr, wrapping at N (not at 2**SEL_W).
  always_comb begin
    rot     = '0;
    rot_sum = '0;
    for (int k = 0; k < N; k++) begin
      rot_sum = {1'b0, ptr} + (SEL_W+1)'(k);
      if (rot_sum >= (SEL_W+1)'(N)) rot_sum = rot_sum - (SEL_W+1)'(N);
      rot[k] = req[rot_sum[SEL_W-1:0]];
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    off     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_vld = 1'b1;
        off     = (SEL_W+1)'(k);
      end
    end
    idx_sum = {1'b0, ptr} + off;
    if (idx_sum >= (SEL_W+1)'(N)) idx_sum = idx_sum - (SEL_W+1)'(N);
    gnt_idx = idx_sum[SEL_W-1:0];
  end

endmodule

// File: rtl/stream_mux_n.sv
// rtl/stream_mux_n.sv - N-to-1 valid/ready stream mux with one-deep output register
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 2,
  parameter int MODE  = MODE_SEL,
  parameter int SEL_W = clog2_min1(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  input  logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic [SEL_W-1:0] grant_idx
);

  logic [W-1:0]     ch_data [N];
  logic             can_load;
  logic             cand_vld;
  logic [SEL_W-1:0] cand_idx;
  logic             load;

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch_data[i] = in_data[i*W +: W];
  end

  assign can_load = !out_valid | out_ready;

  if (MODE == MODE_RR) begin : g_rr
    logic [SEL_W-1:0] rr_ptr;

    rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
      .req     (in_valid),
      .ptr     (rr_ptr),
      .gnt_vld (cand_vld),
      .gnt_idx (cand_idx)
    );

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rr_ptr <= '0;
      end else if (load) begin
        rr_ptr <= (cand_idx == SEL_W'(N - 1)) ? '0 : cand_idx + 1'b1;
      end
    end
  end else begin : g_sel
    // Out-of-range selects (possible when N is not a power of two) pick nothing.
    assign cand_vld = ({1'b0, sel} < (SEL_W+1)'(N));
    assign cand_idx = sel;
  end

  // Gating with reset keeps every ready low while reset is held, not just after an edge.
  always_comb begin
    in_ready = '0;
    if (reset && can_load && cand_vld) in_ready[cand_idx] = 1'b1;
  end

  assign load = cand_vld & in_valid[cand_idx] & in_ready[cand_idx];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant_idx <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[cand_idx];
      grant_idx <= cand_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
